vid_stream_gen: RTL and testbench



---
 rtl/vid_stream_gen.sv | 128 ++++++++++++
 tb/tb_vid_stream_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vid_stream_gen.sv
// vid_stream_gen: di/de/hs/vs test-pattern video source with configurable geometry and blanking
// Ports: clk, rst (sync, active-high); en run request; cfg_* frame geometry, blanking, pattern;
//        do_o/de_o pixel data/valid; hs_o/vs_o line/frame blanking; busy_o in-frame;
//        frame_done_o pulse on last VBLANK cycle; fr_cnt_o completed frame count.
module vid_stream_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int PIX_PERIOD = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_height,
  input  logic [CNT_WIDTH-1:0]  cfg_hblank,
  input  logic [CNT_WIDTH-1:0]  cfg_vblank,
  input  logic [1:0]            cfg_pattern,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [CNT_WIDTH-1:0]  fr_cnt_o
);
  localparam int SW = PIX_PERIOD > 1 ? $clog2(PIX_PERIOD) : 1;
  localparam logic [SW-1:0] SLAST = SW'(PIX_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, LINE, HBLANK, VBLANK} state_t;
  state_t st, n_st;
  logic [CNT_WIDTH-1:0] x, y, b, n_x, n_y, n_b;
  logic [CNT_WIDTH-1:0] lw, lh, lhb, lvb, n_w, n_h;
  logic [SW-1:0] sub, n_sub;
  logic [1:0] lpat, n_pat;
  logic start, relatch, n_de, n_fd;
  logic [DATA_WIDTH-1:0] n_pix;
  // Registers describe the cycle currently on the outputs; the next cycle is
  // computed here so every output can be registered straight from it.
  always_comb begin
    start = en && cfg_width != '0 && cfg_height != '0;
    n_st = st;
    n_x = x;
    n_y = y;
    n_b = b;
    n_sub = sub;
    case (st)
      IDLE: if (start) begin
        n_st = LINE;
        n_x = '0;
        n_y = '0;
        n_sub = '0;
      end
      LINE: if (sub != SLAST) n_sub = sub + 1'b1;
      else if (x != lw - 1'b1) begin
        n_x = x + 1'b1;
        n_sub = '0;
      end else begin
        n_st = (y != lh - 1'b1) ? HBLANK : VBLANK;
        n_b = '0;
      end
      HBLANK: if (b != lhb) n_b = b + 1'b1;
      else begin
        n_st = LINE;
        n_x = '0;
        n_sub = '0;
        n_y = y + 1'b1;
      end
      VBLANK: if (b != lvb) n_b = b + 1'b1;
      else begin
        n_st = start ? LINE : IDLE;
        n_x = '0;
        n_y = '0;
        n_sub = '0;
      end
      default: n_st = IDLE;
    endcase
    relatch = start && (st == IDLE || (st == VBLANK && b == lvb));
    n_w = relatch ? cfg_width : lw;
    n_h = relatch ? cfg_height : lh;
    n_pat = relatch ? cfg_pattern : lpat;
    n_de = n_st == LINE && n_sub == SLAST;
    n_fd = n_st == VBLANK && n_b == lvb;
    n_pix = n_pat == 2'd0 ? DATA_WIDTH'(n_x) :
            n_pat == 2'd1 ? DATA_WIDTH'(n_y) :
            n_pat == 2'd2 ? DATA_WIDTH'(n_x + n_y + fr_cnt_o) :
            {DATA_WIDTH{n_x == (n_w >> 1) && n_y == (n_h >> 1)}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      x <= '0;
      y <= '0;
      b <= '0;
      sub <= '0;
      lw <= '0;
      lh <= '0;
      lhb <= '0;
      lvb <= '0;
      lpat <= '0;
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b1;
      vs_o <= 1'b1;
      busy_o <= 1'b0;
      frame_done_o <= 1'b0;
      fr_cnt_o <= '0;
    end else begin
      st <= n_st;
      x <= n_x;
      y <= n_y;
      b <= n_b;
      sub <= n_sub;
      lw <= n_w;
      lh <= n_h;
      lpat <= n_pat;
      if (relatch) begin
        lhb <= cfg_hblank - CNT_WIDTH'(cfg_hblank != '0);
        lvb <= cfg_vblank - CNT_WIDTH'(cfg_vblank != '0);
      end
      de_o <= n_de;
      if (n_de) do_o <= n_pix;
      hs_o <= n_st != LINE;
      vs_o <= n_st == VBLANK || n_st == IDLE;
      busy_o <= n_st != IDLE;
      frame_done_o <= n_fd;
      fr_cnt_o <= fr_cnt_o + CNT_WIDTH'(n_fd);
    end
  end
endmodule

// File: tb/tb_vid_stream_gen.sv
// tb_vid_stream_gen: directed table and corner-sequence bench for vid_stream_gen at PIX_PERIOD 1 and 2
module tb_vid_stream_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sel = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0, cfg_hblank = '0, cfg_vblank = '0;
  logic [1:0] cfg_pattern = '0;
  logic [7:0] do1, do2, o_do;
  logic de1, de2, hs1, hs2, vs1, vs2, busy1, busy2, fd1, fd2;
  logic o_de, o_hs, o_vs, o_busy, o_fd;
  logic [15:0] fr1, fr2, o_fr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  vid_stream_gen #(.DATA_WIDTH(8), .PIX_PERIOD(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .en(en), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank), .cfg_pattern(cfg_pattern),
    .do_o(do1), .de_o(de1), .hs_o(hs1), .vs_o(vs1), .busy_o(busy1),
    .frame_done_o(fd1), .fr_cnt_o(fr1));
  vid_stream_gen #(.DATA_WIDTH(8), .PIX_PERIOD(2), .CNT_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .en(en), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank), .cfg_pattern(cfg_pattern),
    .do_o(do2), .de_o(de2), .hs_o(hs2), .vs_o(vs2), .busy_o(busy2),
    .frame_done_o(fd2), .fr_cnt_o(fr2));
  assign o_do = sel ? do2 : do1;
  assign o_de = sel ? de2 : de1;
  assign o_hs = sel ? hs2 : hs1;
  assign o_vs = sel ? vs2 : vs1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_fd = sel ? fd2 : fd1;
  assign o_fr = sel ? fr2 : fr1;
  typedef struct {
    bit sel;
    int w, h, hb, vb, pat;
    int len, nde, first, sum, last, nhb, nvb;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic set_cfg(input int w, input int h, input int hb, input int vb, input int pat);
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    cfg_hblank = 16'(hb);
    cfg_vblank = 16'(vb);
    cfg_pattern = 2'(pat);
  endtask
  task automatic run_vec(input int i, input vec_t v);
    int len, nde, first, sum, last, nhb, nvb, nfd;
    sel = v.sel;
    set_cfg(v.w, v.h, v.hb, v.vb, v.pat);
    do_reset();
    chk($sformatf("v%0d reset hs", i), 64'(o_hs), 64'd1);
    chk($sformatf("v%0d reset busy", i), 64'(o_busy), 64'd0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    len = 0; nde = 0; first = -1; sum = 0; last = -1; nhb = 0; nvb = 0; nfd = 0;
    while (o_busy === 1'b1 && len < 5000) begin
      if (o_de) begin
        if (first < 0) first = len;
        nde++;
        sum += int'(o_do);
        last = int'(o_do);
      end
      if (o_hs && !o_vs) nhb++;
      if (o_vs) nvb++;
      if (o_fd) nfd++;
      len++;
      @(negedge clk);
    end
    chk($sformatf("v%0d frame length", i), 64'(len), 64'(v.len));
    chk($sformatf("v%0d de beats", i), 64'(nde), 64'(v.nde));
    chk($sformatf("v%0d first de cycle", i), 64'(first), 64'(v.first));
    chk($sformatf("v%0d pixel sum", i), 64'(sum), 64'(v.sum));
    chk($sformatf("v%0d last pixel", i), 64'(last), 64'(v.last));
    chk($sformatf("v%0d hblank cycles", i), 64'(nhb), 64'(v.nhb));
    chk($sformatf("v%0d vblank cycles", i), 64'(nvb), 64'(v.nvb));
    chk($sformatf("v%0d frame_done pulses", i), 64'(nfd), 64'd1);
    chk($sformatf("v%0d fr_cnt", i), 64'(o_fr), 64'd1);
    chk($sformatf("v%0d idle hs&vs", i), 64'({o_hs, o_vs, o_de, o_fd}), 64'b1100);
  endtask
  task automatic cap(output logic [63:0] deb, output logic [63:0] hsb, output logic [63:0] vsb, output int len);
    deb = '0; hsb = '0; vsb = '0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    len = 0;
    while (o_busy === 1'b1 && len < 64) begin
      deb[len] = o_de;
      hsb[len] = o_hs;
      vsb[len] = o_vs;
      len++;
      @(negedge clk);
    end
  endtask
  initial begin
    logic [63:0] deb, hsb, vsb;
    int len, f;
    int fde[3], fpx[3];
    vt[0] = '{0, 4, 3, 2, 5, 0, 21, 12, 0, 18, 3, 4, 5};
    vt[1] = '{1, 4, 3, 2, 5, 0, 33, 12, 1, 18, 3, 4, 5};
    vt[2] = '{1, 25, 25, 1, 1, 3, 1275, 625, 1, 255, 0, 24, 1};
    vt[3] = '{0, 300, 1, 3, 2, 0, 302, 300, 0, 33586, 43, 0, 2};
    vt[4] = '{0, 1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 1};
    vt[5] = '{0, 3, 2, 0, 3, 1, 10, 6, 0, 3, 1, 1, 3};
    vt[6] = '{1, 2, 2, 1, 1, 2, 10, 4, 1, 4, 2, 1, 1};
    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);
    sel = 1'b0;
    set_cfg(4, 3, 2, 5, 0);
    do_reset();
    cap(deb, hsb, vsb, len);
    chk("first frame len", 64'(len), 64'd21);
    chk("first frame de bits", deb, 64'h00F3CF);
    chk("first frame hs bits", hsb, 64'h1F0C30);
    chk("first frame vs bits", vsb, 64'h1F0000);
    do_reset();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid-line de at x2y1", 64'(o_de), 64'd1);
    chk("mid-line do at x2y1", 64'(o_do), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst outputs", 64'({o_de, o_hs, o_vs, o_busy, o_fd}), 64'b01100);
    chk("rst fr_cnt", 64'(o_fr), 64'd0);
    chk("rst do", 64'(o_do), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst idle busy", 64'(o_busy), 64'd0);
    cap(deb, hsb, vsb, len);
    chk("restart len", 64'(len), 64'd21);
    chk("restart de bits", deb, 64'h00F3CF);
    chk("restart hs bits", hsb, 64'h1F0C30);
    chk("restart vs bits", vsb, 64'h1F0000);
    chk("restart fr_cnt", 64'(o_fr), 64'd1);
    set_cfg(4, 2, 1, 2, 2);
    do_reset();
    en = 1'b1;
    @(negedge clk);
    len = 0;
    f = 0;
    fde = '{0, 0, 0};
    fpx = '{-1, -1, -1};
    while (o_busy === 1'b1 && len < 200) begin
      if (len == 14) cfg_width = 16'd6;
      if (len == 25) en = 1'b0;
      if (o_de && f < 3) begin
        if (fde[f] == 0) fpx[f] = int'(o_do);
        fde[f]++;
      end
      if (o_fd) f++;
      len++;
      @(negedge clk);
    end
    chk("b2b busy run", 64'(len), 64'd37);
    chk("b2b frames", 64'(f), 64'd3);
    chk("b2b fr_cnt", 64'(o_fr), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b frame%0d beats", k), 64'(fde[k]), k == 2 ? 64'd12 : 64'd8);
      chk($sformatf("b2b frame%0d first pixel", k), 64'(fpx[k]), 64'(k));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
